// File: rtl/rr_addr_arbiter_pkg.sv
// Shared definitions for the round-robin address arbiter: state encodings,
// default parameters and the wrap-around search helper.
package rr_addr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_GRANT   = 2'b01,
      ST_RELEASE = 2'b10
   } state_e;

   localparam int DEF_MAX_HOLD = 16;
   localparam int DEF_CNT_W    = 5;
   localparam int NUM_REQ      = 4;

   // Index visited at search step k (1..4) when the last winner was ptr.
   function automatic logic [1:0] rr_slot(input logic [1:0] ptr, input int k);
      return ptr + 2'(k);
   endfunction

endpackage

// File: rtl/rr_addr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter that feeds the
// downstream 2-to-4 decoder.
interface rr_addr_arbiter_if;
   logic [3:0] req;
   logic       done;
   logic       addr0;
   logic       addr1;
   logic       enable;
   logic       busy;
   logic       timeout;

   modport master (
      output req, done,
      input  addr0, addr1, enable, busy, timeout
   );

   modport slave (
      input  req, done,
      output addr0, addr1, enable, busy, timeout
   );
endinterface

// File: rtl/rr_addr_arbiter_pick4.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr and
// returns the first requester found.
module rr_pick4
   import rr_addr_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] slot;

   // Walk the order backwards so the earliest slot in the search is the last write.
   always_comb begin
      valid = 1'b0;
      idx   = 2'b00;
      slot  = ptr;
      for (int k = NUM_REQ; k >= 1; k--) begin
         slot = rr_slot(ptr, k);
         if (req[slot]) begin
            valid = 1'b1;
            idx   = slot;
         end
      end
   end

endmodule

// File: rtl/rr_addr_arbiter.sv
// Four-way round-robin arbiter driving an encoded grant (addr1:addr0, enable)
// into a 2-to-4 decoder, with done/request-drop/timeout release.
module rr_addr_arbiter
   import rr_addr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   rr_addr_arbiter_if.slave arb
);

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        addr_q, addr_d;
   logic              enable_q, enable_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;

   logic              pick_vld;
   logic [1:0]        pick_idx;
   logic              owner_req;
   logic              hold_exp;
   logic              release_now;

   rr_pick4 u_pick (
      .req   (arb.req),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   // addr_q is only non-zero during GRANT, so it names the owner there.
   assign owner_req   = arb.req[addr_q];
   assign hold_exp    = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
   assign release_now = arb.done || !owner_req || hold_exp;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      enable_d  = enable_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_RELEASE: begin
            if (pick_vld) begin
               state_d  = ST_GRANT;
               ptr_d    = pick_idx;
               addr_d   = pick_idx;
               cnt_d    = CNT_ONE;
               enable_d = 1'b1;
               busy_d   = 1'b1;
            end else begin
               state_d  = ST_IDLE;
               addr_d   = 2'b00;
               cnt_d    = '0;
               enable_d = 1'b0;
               busy_d   = 1'b0;
            end
         end
         ST_GRANT: begin
            if (release_now) begin
               state_d   = ST_RELEASE;
               addr_d    = 2'b00;
               cnt_d     = '0;
               enable_d  = 1'b0;
               busy_d    = 1'b1;
               // done takes precedence over expiry; a dropped request is not a timeout.
               timeout_d = hold_exp && !arb.done && owner_req;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            addr_d   = 2'b00;
            cnt_d    = '0;
            enable_d = 1'b0;
            busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd3;
         cnt_q     <= '0;
         addr_q    <= 2'b00;
         enable_q  <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         enable_q  <= enable_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb.addr0   = addr_q[0];
   assign arb.addr1   = addr_q[1];
   assign arb.enable  = enable_q;
   assign arb.busy    = busy_q;
   assign arb.timeout = timeout_q;

endmodule

// File: tb/tb_rr_addr_arbiter.sv
// Directed bench for rr_addr_arbiter with a cycle-level reference model and
// hand-computed checkpoints along the sequence.
module tb_rr_addr_arbiter;

   localparam int MAXH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   rr_addr_arbiter_if arb();

   rr_addr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (arb)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: who owns the resource, for how many cycles, last winner.
   int m_owner = -1;
   int m_last  = 3;
   int m_held  = 0;
   bit m_rel   = 1'b0;
   bit m_to    = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_owner = -1; m_last = 3; m_held = 0; m_rel = 1'b0; m_to = 1'b0;
      end else if (m_owner >= 0) begin
         if (arb.done || !arb.req[m_owner] || m_held == MAXH) begin
            m_to    = (m_held == MAXH) && !arb.done && arb.req[m_owner];
            m_owner = -1;
            m_rel   = 1'b1;
         end else begin
            m_held++;
         end
      end else begin
         m_to  = 1'b0;
         m_rel = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            if (m_owner < 0 && arb.req[(m_last + k) % 4]) begin
               m_owner = (m_last + k) % 4;
               m_last  = m_owner;
               m_held  = 1;
            end
         end
      end
   end

   // {addr1, addr0, enable, busy, timeout}
   function automatic logic [4:0] model_vec();
      logic [1:0] a;
      a = (m_owner >= 0) ? 2'(m_owner) : 2'b00;
      return {a, m_owner >= 0, (m_owner >= 0) || m_rel, m_to};
   endfunction

   function automatic logic [4:0] dut_vec();
      return {arb.addr1, arb.addr0, arb.enable, arb.busy, arb.timeout};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (a1 a0 en busy to) at %0t", name, act, exp, $time);
   endtask

   task automatic lit(input string name, input logic [4:0] exp);
      check(name, dut_vec(), exp);
      check({name, "_model"}, model_vec(), exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!reset) check("cycle", dut_vec(), model_vec());
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end, expected finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq[4];
      seq = '{1, 2, 3, 0};
      arb.req  = 4'b1111;
      arb.done = 1'b0;

      tick();
      lit("reset_outs", 5'b00000);
      reset = 1'b0;
      tick();
      lit("first_grant", 5'b00110);

      // Rotation with done held: grant/release alternate, busy stays high.
      arb.done = 1'b1;
      foreach (seq[i]) begin
         tick();
         lit($sformatf("rot_rel%0d", i), 5'b00010);
         tick();
         lit($sformatf("rot_grant%0d", i), {2'(seq[i]), 3'b110});
      end

      // Sparse requests after owning index 0.
      arb.req = 4'b0101;
      tick(); lit("sparse_rel0", 5'b00010);
      tick(); lit("sparse_g2", 5'b10110);
      tick(); lit("sparse_rel1", 5'b00010);
      tick(); lit("sparse_g0", 5'b00110);

      // Owner drops its request: release without timeout, then index 1.
      arb.done = 1'b0;
      arb.req  = 4'b0010;
      tick(); lit("drop_rel", 5'b00010);
      tick(); lit("to_g1", 5'b01110);

      // No done: exactly MAXH enable cycles, then one timeout pulse.
      for (int i = 2; i <= MAXH; i++) begin
         tick(); lit($sformatf("to_hold%0d", i), 5'b01110);
      end
      tick(); lit("to_pulse", 5'b00011);
      tick(); lit("to_regrant", 5'b01110);

      // done on the final hold cycle wins over expiry.
      for (int i = 2; i <= MAXH; i++) tick();
      lit("tie_last_hold", 5'b01110);
      arb.done = 1'b1;
      tick(); lit("tie_no_to", 5'b00010);
      arb.done = 1'b0;
      tick(); lit("tie_regrant", 5'b01110);

      // Asynchronous reset between edges during a grant.
      arb.req = 4'b0110;
      #2 reset = 1'b1;
      #1 lit("async_rst", 5'b00000);
      reset = 1'b0;
      tick(); lit("post_rst_grant", 5'b01110);
      arb.req = 4'b0000;
      tick(); lit("final_rel", 5'b00010);
      tick(); lit("final_idle", 5'b00000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
